psr_flag_unit: RTL and testbench
================================

Name: psr_flag_unit

Overview:
- Producer side of the NZCV flag interface consumed by the branch condition evaluator in ID.
- Holds the architectural PSR flags and commits updates from single-cycle EX instructions with the S bit.
- Also commits updates from multi-cycle flag-setting ops (e.g. MUL with S) that finish MC_LAT cycles after issue.
- Drives bypassed flags to ID and a stall request while a multi-cycle flag result is outstanding.

Parameters:
- MC_LAT, 2, cycles from mc_start to the mc_flags commit; legal range 1..15.
- FLAG_RESET, 4'b0000, reset value of the PSR flags [N,Z,C,V].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  a valid instruction is in EX.
- ex_s_bit  input  1  the EX instruction updates flags.
- alu_flags  input  4  single-cycle ALU result flags [N,Z,C,V].
- mc_start  input  1  one-cycle pulse: a multi-cycle flag-setting op issued this cycle.
- mc_flags  input  4  multi-cycle result flags, valid in the commit cycle.
- flush  input  1  cancels the EX update this cycle and any pending multi-cycle update.
- id_cond_used  input  1  the ID instruction reads flags (condition code is not AL/NV).
- flags  output  4  flags presented to the condition evaluator (bypassed).
- psr_q  output  4  committed architectural flags.
- flag_stall  output  1  stall ID: flags not yet available.
- mc_pending  output  1  a multi-cycle flag update is outstanding.
- spsr_q  output  4  saved flags (see Optional Feature).
- save_psr, restore_psr  input  1 each  exception save / return restore (see Optional Feature).

Behaviour:
Reset (asynchronous, immediate on reset high):
- psr_q = FLAG_RESET; FSM = IDLE; counter = 0; spsr_q = 0.
- mc_pending = 0; flag_stall = 0.
- flags = FLAG_RESET unless the bypass is active.

Single-cycle write:
- Condition: ex_valid & ex_s_bit & ~flush.
- Action: psr_q <= alu_flags on the next edge.

Bypass (combinational, zero latency):
- flags = alu_flags when ex_valid & ex_s_bit & ~flush.
- Otherwise flags = mc_flags in the multi-cycle commit cycle.
- Otherwise flags = psr_q.

FSM states:
- IDLE
  - mc_start & ~flush -> PEND, counter <= MC_LAT-1.
  - mc_start & flush -> stays IDLE.
- PEND
  - counter != 0 -> counter decrements each cycle.
  - counter == 0 is the commit cycle: psr_q <= mc_flags, FSM -> IDLE.
  - flush in any PEND cycle, including the commit cycle -> IDLE, no commit.
  - mc_start while PEND -> counter reloads to MC_LAT-1; the earlier op is superseded and never commits.

Outputs:
- mc_pending = (FSM == PEND).
- flag_stall = id_cond_used & mc_pending & ~(commit cycle). The commit cycle bypasses mc_flags instead of stalling.

Simultaneous events:
- EX single-cycle write and mc commit in the same cycle: the EX write is younger and wins; psr_q <= alu_flags.
- The bypass follows the same priority.

Other rules:
- flush does not alter psr_q; it only cancels the same-cycle write and the pending op.
- Reset asserted mid-PEND aborts the pending op; no commit after reset release.
- Widths: all flag paths are exactly 4 bits; no arithmetic on flags.
- The counter is 4 bits.

Optional Feature:
PSR_SPSR_EN
- Defined:
  - save_psr: spsr_q <= flags (bypassed value) on the next edge.
  - restore_psr: psr_q <= spsr_q; this beats every other psr_q write in that cycle.
  - flags bypass = spsr_q while restore_psr is high.
  - save_psr and restore_psr together: restore takes effect and spsr_q also updates.
- Undefined:
  - save_psr and restore_psr are ignored.
  - spsr_q is constant 4'b0000 and no SPSR register is synthesised.

Test Plan:
- Reset with FLAG_RESET=0: psr_q=0000, flags=0000, flag_stall=0, mc_pending=0. Assert reset mid-PEND -> mc_pending drops immediately.
- ex_valid=1, ex_s_bit=1, alu_flags=0100 -> flags=0100 in the same cycle, psr_q=0100 after the edge. Repeat with flush=1 -> psr_q unchanged.
- MC_LAT=2: mc_start, id_cond_used=1, mc_flags=1001 in the commit cycle.
  - flag_stall=1 in the cycle after mc_start.
  - flag_stall=0 and flags=1001 in the commit cycle.
  - psr_q=1001 after the commit edge.
- Commit cycle with ex_s_bit=1, alu_flags=0010, mc_flags=1000 -> psr_q=0010. Separately, flush in the commit cycle -> psr_q keeps its prior value and mc_pending=0.
- mc_start again while PEND -> exactly one commit, MC_LAT cycles after the second start.
- PSR_SPSR_EN: psr_q=0110; save_psr -> spsr_q=0110. EX write 0001 -> psr_q=0001. restore_psr -> flags=0110 in the same cycle, psr_q=0110 after the edge. Without the macro -> spsr_q stays 0000 and psr_q=0001.

Source files
------------

// File: rtl/psr_flag_unit.sv
// psr_flag_unit
//
// Holds the architectural NZCV flags ([N,Z,C,V]) and is the producer side of
// the flag interface read by the branch condition evaluator in ID.
//   - Single-cycle EX instructions with the S bit commit alu_flags_i on the
//     next edge and are bypassed to flags_o in the same cycle.
//   - A multi-cycle flag-setting op issued by mc_start_i commits mc_flags_i
//     MC_LAT cycles later. flag_stall_o holds off a flag-reading ID
//     instruction until that commit cycle, in which mc_flags_i is bypassed.
//   - flush_i cancels the same-cycle EX write and any pending multi-cycle op.
//
// Optional feature (macro PSR_SPSR_EN): a saved-PSR register.
//   - save_psr_i copies the bypassed flags into spsr_q_o.
//   - restore_psr_i copies spsr_q_o into the PSR and bypasses it, beating
//     every other PSR write.
//   Without the macro, save_psr_i and restore_psr_i are ignored and
//   spsr_q_o is tied to 4'b0000.
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_i         asynchronous active-high reset
//   ex_valid_i      valid instruction in EX
//   ex_s_bit_i      EX instruction updates flags
//   alu_flags_i     single-cycle ALU flags
//   mc_start_i      multi-cycle flag-setting op issued this cycle
//   mc_flags_i      multi-cycle result flags, valid in the commit cycle
//   flush_i         cancel EX write and pending multi-cycle op
//   id_cond_used_i  ID instruction reads flags
//   save_psr_i      exception entry: save flags
//   restore_psr_i   exception return: restore flags
//   flags_o         bypassed flags for the condition evaluator
//   psr_q_o         committed architectural flags
//   flag_stall_o    stall ID, flags not yet available
//   mc_pending_o    multi-cycle flag update outstanding
//   spsr_q_o        saved flags

module psr_flag_unit #(
  parameter int unsigned MC_LAT     = 2,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ex_valid_i,
  input  logic       ex_s_bit_i,
  input  logic [3:0] alu_flags_i,
  input  logic       mc_start_i,
  input  logic [3:0] mc_flags_i,
  input  logic       flush_i,
  input  logic       id_cond_used_i,
  input  logic       save_psr_i,
  input  logic       restore_psr_i,
  output logic [3:0] flags_o,
  output logic [3:0] psr_q_o,
  output logic       flag_stall_o,
  output logic       mc_pending_o,
  output logic [3:0] spsr_q_o
);

  localparam logic [3:0] CntLoad = 4'(MC_LAT - 1);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] psr_q, psr_d;

  logic ex_wr;
  logic mc_last;    // PEND with the counter expired: the commit cycle
  logic mc_commit;  // commit cycle not cancelled by flush
  logic restore;

  assign ex_wr     = ex_valid_i & ex_s_bit_i & ~flush_i;
  assign mc_last   = (state_q == StPend) && (cnt_q == 4'd0);
  assign mc_commit = mc_last & ~flush_i;

`ifdef PSR_SPSR_EN
  logic [3:0] spsr_q, spsr_d;

  assign restore = restore_psr_i;
  assign spsr_d  = save_psr_i ? flags_o : spsr_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      spsr_q <= 4'b0000;
    end else begin
      spsr_q <= spsr_d;
    end
  end

  assign spsr_q_o = spsr_q;
`else
  logic [3:0] spsr_q;
  logic       unused_spsr_ctrl;

  assign restore          = 1'b0;
  assign spsr_q           = 4'b0000;
  assign spsr_q_o         = spsr_q;
  assign unused_spsr_ctrl = save_psr_i ^ restore_psr_i;
`endif

  // Bypass and commit share one priority: restore, then the younger EX
  // write, then the multi-cycle commit.
  always_comb begin
    flags_o = psr_q;
    if (restore) begin
      flags_o = spsr_q;
    end else if (ex_wr) begin
      flags_o = alu_flags_i;
    end else if (mc_commit) begin
      flags_o = mc_flags_i;
    end
  end

  assign psr_d = flags_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      psr_q <= FLAG_RESET;
    end else begin
      psr_q <= psr_d;
    end
  end

  assign psr_q_o = psr_q;

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mc_start_i && !flush_i) begin
          state_d = StPend;
          cnt_d   = CntLoad;
        end
      end
      StPend: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (mc_start_i) begin
          // A new op supersedes the outstanding one, which never commits.
          cnt_d = CntLoad;
        end else if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    mc_pending_o = (state_q == StPend);
    // The commit cycle bypasses mc_flags_i instead of stalling.
    flag_stall_o = id_cond_used_i & mc_pending_o & ~mc_last;
  end

endmodule

// File: tb/tb_psr_flag_unit.sv
// Directed self-checking bench for psr_flag_unit (MC_LAT = 2, FLAG_RESET = 0).
module tb_psr_flag_unit;

  logic       clk;
  logic       reset;
  logic       ex_valid;
  logic       ex_s_bit;
  logic [3:0] alu_flags;
  logic       mc_start;
  logic [3:0] mc_flags;
  logic       flush;
  logic       id_cond_used;
  logic       save_psr;
  logic       restore_psr;
  logic [3:0] flags;
  logic [3:0] psr_q;
  logic       flag_stall;
  logic       mc_pending;
  logic [3:0] spsr_q;

  int n_vec = 0;
  int n_err = 0;

  psr_flag_unit #(
    .MC_LAT    (2),
    .FLAG_RESET(4'b0000)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .ex_valid_i    (ex_valid),
    .ex_s_bit_i    (ex_s_bit),
    .alu_flags_i   (alu_flags),
    .mc_start_i    (mc_start),
    .mc_flags_i    (mc_flags),
    .flush_i       (flush),
    .id_cond_used_i(id_cond_used),
    .save_psr_i    (save_psr),
    .restore_psr_i (restore_psr),
    .flags_o       (flags),
    .psr_q_o       (psr_q),
    .flag_stall_o  (flag_stall),
    .mc_pending_o  (mc_pending),
    .spsr_q_o      (spsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs can be changed right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_s_bit = 1'b0; alu_flags = 4'b0000;
    mc_start = 1'b0; mc_flags = 4'b0000; flush = 1'b0; id_cond_used = 1'b0;
    save_psr = 1'b0; restore_psr = 1'b0;

    // Reset state
    step();
    check("rst_psr",     psr_q, 4'b0000);
    check("rst_flags",   flags, 4'b0000);
    check("rst_stall",   4'(flag_stall), 4'd0);
    check("rst_pending", 4'(mc_pending), 4'd0);
    check("rst_spsr",    spsr_q, 4'b0000);
    reset = 1'b0;
    step();

    // Single-cycle write with bypass
    ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0100;
    #1 check("ex_bypass", flags, 4'b0100);
    check("ex_psr_before", psr_q, 4'b0000);
    step();
    check("ex_psr_after", psr_q, 4'b0100);
    // Flushed write is cancelled and not bypassed
    flush = 1'b1; alu_flags = 4'b1111;
    #1 check("flush_bypass", flags, 4'b0100);
    step();
    check("flush_psr", psr_q, 4'b0100);
    flush = 1'b0; ex_valid = 1'b0; ex_s_bit = 1'b0;

    // Multi-cycle op, MC_LAT = 2
    mc_start = 1'b1; id_cond_used = 1'b1;
    #1 check("mc_issue_stall", 4'(flag_stall), 4'd0);
    step();
    mc_start = 1'b0;
    #1 check("mc_wait_pending", 4'(mc_pending), 4'd1);
    check("mc_wait_stall", 4'(flag_stall), 4'd1);
    check("mc_wait_flags", flags, 4'b0100);
    step();
    mc_flags = 4'b1001;
    #1 check("mc_commit_stall", 4'(flag_stall), 4'd0);
    check("mc_commit_flags", flags, 4'b1001);
    check("mc_commit_pending", 4'(mc_pending), 4'd1);
    step();
    check("mc_commit_psr", psr_q, 4'b1001);
    check("mc_done_pending", 4'(mc_pending), 4'd0);
    check("mc_done_stall", 4'(flag_stall), 4'd0);

    // EX write beats the commit in the same cycle
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0010; mc_flags = 4'b1000;
    #1 check("ex_vs_mc_flags", flags, 4'b0010);
    step();
    check("ex_vs_mc_psr", psr_q, 4'b0010);
    ex_valid = 1'b0; ex_s_bit = 1'b0;

    // Flush in the commit cycle: no commit
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    flush = 1'b1; mc_flags = 4'b1111;
    #1 check("flush_commit_flags", flags, 4'b0010);
    step();
    flush = 1'b0;
    check("flush_commit_psr", psr_q, 4'b0010);
    check("flush_commit_pending", 4'(mc_pending), 4'd0);

    // Restart while pending: only the second op commits, 2 cycles after it
    mc_start = 1'b1;
    step();
    step();  // second start, one cycle after the first
    mc_start = 1'b0; mc_flags = 4'b1110;
    #1 check("restart_no_early", flags, 4'b0010);
    check("restart_stall", 4'(flag_stall), 4'd1);
    step();
    mc_flags = 4'b0101;
    #1 check("restart_commit_flags", flags, 4'b0101);
    step();
    check("restart_psr", psr_q, 4'b0101);
    check("restart_pending", 4'(mc_pending), 4'd0);
    mc_flags = 4'b1100;
    step();
    check("restart_single", psr_q, 4'b0101);

    // Reset mid-PEND aborts the op immediately
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    #1 check("rstmid_pending_pre", 4'(mc_pending), 4'd1);
    reset = 1'b1;
    #1 check("rstmid_pending", 4'(mc_pending), 4'd0);
    check("rstmid_psr", psr_q, 4'b0000);
    check("rstmid_stall", 4'(flag_stall), 4'd0);
    step();
    reset = 1'b0; mc_flags = 4'b1111;
    step();
    step();
    check("rstmid_no_commit", psr_q, 4'b0000);
    id_cond_used = 1'b0;

    // Saved PSR
    ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0110;
    step();
    ex_valid = 1'b0; ex_s_bit = 1'b0;
    check("spsr_setup_psr", psr_q, 4'b0110);
    save_psr = 1'b1;
    step();
    save_psr = 1'b0;
`ifdef PSR_SPSR_EN
    check("spsr_saved", spsr_q, 4'b0110);
`else
    check("spsr_saved", spsr_q, 4'b0000);
`endif
    ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0001;
    step();
    ex_valid = 1'b0; ex_s_bit = 1'b0;
    check("spsr_ex_psr", psr_q, 4'b0001);
    restore_psr = 1'b1;
`ifdef PSR_SPSR_EN
    #1 check("restore_flags", flags, 4'b0110);
    step();
    check("restore_psr", psr_q, 4'b0110);
`else
    #1 check("restore_flags", flags, 4'b0001);
    step();
    check("restore_psr", psr_q, 4'b0001);
    check("spsr_const", spsr_q, 4'b0000);
`endif
    restore_psr = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
